sn_arbiter: RTL and testbench

Round-robin arbiter that shares one snooper among `N_CORES` parallel `packetfilter_core` instances. It watches each core's `rdy_for_sn` and offers one ready core to the snooper at a time. When the snooper acknowledges, it forwards the ack to that core only, and it steers write strobes and `sn_done` to that core until the packet ends. It sits between the snooper and the parallel-core array, and owns the snooper-side handshake.

---
 rtl/sn_arbiter.sv | 152 +++++++++++++++
 tb/tb_sn_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn_arbiter.sv
// sn_arbiter: round-robin arbiter that shares one snooper among N_CORES packet-filter cores.
// Ports: clk/rst; snooper side (sn_*, rdy_for_sn, rdy_for_sn_ack); core side (core_sn_* broadcast,
//        per-core core_sn_wr_en/core_sn_done/core_rdy_for_sn/core_rdy_for_sn_ack); status (sel_core, busy, sn_err).
// Latency: offer 1 cycle after a core becomes ready in IDLE; ack and strobe steering are combinational.
module sn_arbiter #(
  parameter int N_CORES           = 4,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int INC_WIDTH         = 4,
  parameter int SEL_WIDTH         = $clog2(N_CORES)
) (
  input  logic                         clk,
  input  logic                         rst,
  // snooper side
  input  logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
  input  logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
  input  logic                         sn_wr_en,
  input  logic [INC_WIDTH-1:0]         sn_byte_inc,
  input  logic                         sn_done,
  output logic                         rdy_for_sn,
  input  logic                         rdy_for_sn_ack,
  // core side
  output logic [SN_FWD_ADDR_WIDTH-1:0] core_sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0] core_sn_wr_data,
  output logic [INC_WIDTH-1:0]         core_sn_byte_inc,
  output logic [N_CORES-1:0]           core_sn_wr_en,
  output logic [N_CORES-1:0]           core_sn_done,
  input  logic [N_CORES-1:0]           core_rdy_for_sn,
  output logic [N_CORES-1:0]           core_rdy_for_sn_ack,
  // status
  output logic [SEL_WIDTH-1:0]         sel_core,
  output logic                         busy,
  output logic                         sn_err
);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_ACTIVE} state_t;

  state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] pick;
  logic                 any_rdy;
  logic                 sel_rdy;
  logic                 err_q, err_d;
  logic [N_CORES-1:0]   sel_onehot;

  // Data buses are shared by all cores; only the strobes are steered.
  assign core_sn_addr     = sn_addr;
  assign core_sn_wr_data  = sn_wr_data;
  assign core_sn_byte_inc = sn_byte_inc;

  assign sel_core = sel_q;
  assign busy     = (state_q == S_ACTIVE);
  assign sn_err   = err_q;

  // Round-robin pick. Descending loops let the lowest matching index win:
  // the first pass gives the wrap-around fallback (lowest ready overall),
  // the second overrides it with the lowest ready index at or above ptr.
  always_comb begin
    pick    = '0;
    any_rdy = 1'b0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (core_rdy_for_sn[i]) begin
        pick    = SEL_WIDTH'(i);
        any_rdy = 1'b1;
      end
    end
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (core_rdy_for_sn[i] && (i >= int'(ptr_q))) begin
        pick = SEL_WIDTH'(i);
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < N_CORES; i++) begin
      sel_onehot[i] = (sel_q == SEL_WIDTH'(i));
    end
  end

  assign sel_rdy = |(core_rdy_for_sn & sel_onehot);

  always_comb begin
    state_d             = state_q;
    ptr_d               = ptr_q;
    sel_d               = sel_q;
    err_d               = err_q;
    rdy_for_sn          = 1'b0;
    core_rdy_for_sn_ack = '0;
    core_sn_wr_en       = '0;
    core_sn_done        = '0;

    case (state_q)
      S_IDLE: begin
        if (any_rdy) begin
          sel_d   = pick;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        rdy_for_sn = sel_rdy;
        // A ready-drop wins over a same-cycle ack: the ack is then an error.
        if (!sel_rdy) begin
          state_d = S_IDLE;
        end else if (rdy_for_sn_ack) begin
          core_rdy_for_sn_ack = sel_onehot;
          state_d             = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        core_sn_wr_en = {N_CORES{sn_wr_en}} & sel_onehot;
        core_sn_done  = {N_CORES{sn_done}} & sel_onehot;
        if (sn_done) begin
          ptr_d   = (sel_q == SEL_WIDTH'(N_CORES - 1)) ? '0 : sel_q + SEL_WIDTH'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stray strobes outside ACTIVE are simply never steered above, so the
    // only extra work is recording the protocol violation.
    if ((rdy_for_sn_ack && !rdy_for_sn) ||
        ((sn_wr_en || sn_done) && (state_q != S_ACTIVE))) begin
      err_d = 1'b1;
    end

    // No strobe may leak out during the reset cycle, whatever the old state.
    if (rst) begin
      rdy_for_sn          = 1'b0;
      core_rdy_for_sn_ack = '0;
      core_sn_wr_en       = '0;
      core_sn_done        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sn_arbiter.sv
module tb_sn_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] sn_addr;
  logic [DW-1:0] sn_wr_data;
  logic          sn_wr_en;
  logic [IW-1:0] sn_byte_inc;
  logic          sn_done;
  logic          rdy_for_sn;
  logic          rdy_for_sn_ack;
  logic [AW-1:0] core_sn_addr;
  logic [DW-1:0] core_sn_wr_data;
  logic [IW-1:0] core_sn_byte_inc;
  logic [N-1:0]  core_sn_wr_en;
  logic [N-1:0]  core_sn_done;
  logic [N-1:0]  core_rdy_for_sn;
  logic [N-1:0]  core_rdy_for_sn_ack;
  logic [SW-1:0] sel_core;
  logic          busy;
  logic          sn_err;

  always #5 clk = ~clk;

  sn_arbiter #(.N_CORES(N), .SN_FWD_ADDR_WIDTH(AW), .SN_FWD_DATA_WIDTH(DW),
               .INC_WIDTH(IW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_wr_en(sn_wr_en),
    .sn_byte_inc(sn_byte_inc), .sn_done(sn_done),
    .rdy_for_sn(rdy_for_sn), .rdy_for_sn_ack(rdy_for_sn_ack),
    .core_sn_addr(core_sn_addr), .core_sn_wr_data(core_sn_wr_data),
    .core_sn_byte_inc(core_sn_byte_inc), .core_sn_wr_en(core_sn_wr_en),
    .core_sn_done(core_sn_done), .core_rdy_for_sn(core_rdy_for_sn),
    .core_rdy_for_sn_ack(core_rdy_for_sn_ack),
    .sel_core(sel_core), .busy(busy), .sn_err(sn_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0=waiting, 1=offering m_sel, 2=packet on m_sel.
  int m_phase = 0;
  int m_sel   = 0;
  int m_ptr   = 0;
  bit m_err   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scan ready cores starting at ptr and wrapping modulo N.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      if (core_rdy_for_sn[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] one;
    logic [N-1:0] oh;
    logic         sel_ready;
    bit           live;
    one       = 1;
    oh        = one << m_sel;
    sel_ready = core_rdy_for_sn[m_sel];
    live      = !rst;
    chk("rdy_for_sn", rdy_for_sn, live && m_phase == 1 && sel_ready);
    chk("ack_vec", core_rdy_for_sn_ack,
        (live && m_phase == 1 && sel_ready && rdy_for_sn_ack) ? oh : '0);
    chk("wr_vec", core_sn_wr_en, (live && m_phase == 2 && sn_wr_en) ? oh : '0);
    chk("done_vec", core_sn_done, (live && m_phase == 2 && sn_done) ? oh : '0);
    chk("sel_core", sel_core, m_sel);
    chk("busy", busy, m_phase == 2);
    chk("sn_err", sn_err, m_err);
    chk("bc_addr", core_sn_addr, sn_addr);
    chk("bc_data", core_sn_wr_data, sn_wr_data);
    chk("bc_inc", core_sn_byte_inc, sn_byte_inc);
  endtask

  task automatic model_advance();
    logic sel_ready;
    bit   offered;
    int   p;
    if (rst) begin
      m_phase = 0; m_sel = 0; m_ptr = 0; m_err = 1'b0;
    end else begin
      sel_ready = core_rdy_for_sn[m_sel];
      offered   = (m_phase == 1) && sel_ready;
      if ((rdy_for_sn_ack && !offered) || ((sn_wr_en || sn_done) && m_phase != 2)) m_err = 1'b1;
      case (m_phase)
        0: begin
          p = model_pick();
          if (p >= 0) begin m_sel = p; m_phase = 1; end
        end
        1: begin
          if (!sel_ready) m_phase = 0;
          else if (rdy_for_sn_ack) m_phase = 2;
        end
        default: begin
          if (sn_done) begin m_ptr = (m_sel + 1) % N; m_phase = 0; end
        end
      endcase
    end
  endtask

  task automatic settle();
    #1;
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic quiet();
    rdy_for_sn_ack = 1'b0; sn_wr_en = 1'b0; sn_done = 1'b0;
  endtask

  // One full packet: idle cycle, offer + ack, nwr writes, done.
  task automatic run_packet(input logic [N-1:0] rdy, input int exp_sel, input int nwr);
    logic [N-1:0] one;
    one = 1;
    quiet();
    core_rdy_for_sn = rdy;
    settle();
    chk("pkt_idle_busy", busy, 1'b0);
    chk("pkt_idle_rdy", rdy_for_sn, 1'b0);
    tick();
    settle();
    chk("pkt_offer_sel", sel_core, exp_sel);
    chk("pkt_offer_rdy", rdy_for_sn, 1'b1);
    rdy_for_sn_ack = 1'b1;
    settle();
    chk("pkt_ack", core_rdy_for_sn_ack, one << exp_sel);
    tick();
    rdy_for_sn_ack = 1'b0;
    for (int w = 0; w < nwr; w++) begin
      sn_wr_en    = 1'b1;
      sn_addr     = AW'(w);
      sn_wr_data  = {$urandom, $urandom};
      sn_byte_inc = IW'($urandom);
      settle();
      chk("pkt_wr", core_sn_wr_en, one << exp_sel);
      tick();
    end
    sn_wr_en = 1'b0;
    sn_done  = 1'b1;
    settle();
    chk("pkt_done", core_sn_done, one << exp_sel);
    tick();
    sn_done = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    settle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int exp_seq[7] = '{0, 1, 2, 3, 0, 1, 2};
    rst = 1'b1; core_rdy_for_sn = '0; sn_addr = '0; sn_wr_data = '0; sn_byte_inc = '0;
    quiet();
    tick();
    settle();
    chk("rst_rdy", rdy_for_sn, 1'b0);
    chk("rst_sel", sel_core, 0);
    chk("rst_err", sn_err, 1'b0);
    tick();
    rst = 1'b0;

    // Cores 0 and 2 ready: core 0 first, then ptr=1 makes core 2 next.
    run_packet(4'b0101, 0, 8);
    run_packet(4'b0101, 2, 2);

    // All ready: strict rotation, then core 3 alone with ptr=3 and wrap.
    do_reset();
    for (int p = 0; p < 7; p++) run_packet(4'b1111, exp_seq[p], 1 + p % 3);
    for (int p = 0; p < 3; p++) run_packet(4'b1000, 3, 2);

    // Selected core drops ready before ack: back to idle, no error.
    do_reset();
    core_rdy_for_sn = 4'b0010;
    settle(); tick();
    settle();
    chk("drop_sel", sel_core, 1);
    core_rdy_for_sn = 4'b0000;
    settle();
    chk("drop_rdy", rdy_for_sn, 1'b0);
    chk("drop_ack", core_rdy_for_sn_ack, 4'b0000);
    tick();
    settle();
    chk("drop_busy", busy, 1'b0);
    chk("drop_err", sn_err, 1'b0);

    // Stray write in idle, then ack with nothing offered: sticky error.
    sn_wr_en = 1'b1;
    settle();
    chk("stray_wr", core_sn_wr_en, 4'b0000);
    tick();
    sn_wr_en = 1'b0;
    settle();
    chk("stray_err", sn_err, 1'b1);
    do_reset();
    rdy_for_sn_ack = 1'b1;
    settle();
    chk("stray_ack", core_rdy_for_sn_ack, 4'b0000);
    tick();
    rdy_for_sn_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin settle(); tick(); end
    settle();
    chk("sticky_err", sn_err, 1'b1);

    // Reset mid-packet: strobes killed in the reset cycle, ptr back to 0.
    do_reset();
    run_packet(4'b0010, 1, 1);
    core_rdy_for_sn = 4'b1000;
    settle(); tick();
    rdy_for_sn_ack = 1'b1;
    settle(); tick();
    rdy_for_sn_ack = 1'b0;
    sn_wr_en = 1'b1;
    settle();
    chk("mid_wr", core_sn_wr_en, 4'b1000);
    rst = 1'b1;
    settle();
    chk("rst_wr", core_sn_wr_en, 4'b0000);
    tick();
    rst = 1'b0; sn_wr_en = 1'b0;
    core_rdy_for_sn = 4'b1111;
    settle();
    chk("post_rst_busy", busy, 1'b0);
    tick();
    settle();
    chk("post_rst_sel", sel_core, 0);
    tick();

    // Randomized traffic, mostly legal, against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(99, 0) < 15) core_rdy_for_sn[b] = ~core_rdy_for_sn[b];
      rst            = ($urandom_range(199, 0) == 0);
      rdy_for_sn_ack = (m_phase == 1) ? ($urandom_range(99, 0) < 50) : ($urandom_range(99, 0) < 2);
      sn_wr_en       = (m_phase == 2) ? ($urandom_range(99, 0) < 60) : ($urandom_range(99, 0) < 2);
      sn_done        = (m_phase == 2) ? ($urandom_range(99, 0) < 20) : ($urandom_range(199, 0) < 2);
      sn_addr        = AW'($urandom);
      sn_wr_data     = {$urandom, $urandom};
      sn_byte_inc    = IW'($urandom);
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
